systolic_matmul_engine: RTL and testbench
=========================================

# systolic_matmul_engine

Parametrised ROWS x COLS weight-stationary systolic matrix-vector engine, the generalised successor of the fixed 2x2 systolic core. It adds on-chip activation skew and result deskew, a weight-load/stream/drain state machine, and valid/ready handshakes with full-pipeline backpressure. Each accepted activation vector a produces one result vector y[c] = sum over r of a[r]*W[r][c]. The block sits between the activation/weight buffers and the result writeback path.

## Interface
- ROWS, 4, PE rows; activation lanes and weight beats per load (>=1)
- COLS, 4, PE columns; result lanes (>=1)
- DATA_WIDTH, 16, signed activation width
- WEIGHT_WIDTH, 8, signed weight width
- ACCUM_WIDTH, 32, signed partial-sum/result width (>= DATA_WIDTH+WEIGHT_WIDTH)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- w_valid  in  1  weight row beat valid
- w_ready  out  1  engine accepts a weight row
- w_data  in  COLS*WEIGHT_WIDTH  one row of W; lane c = W[row][c]
- a_valid  in  1  activation vector valid
- a_ready  out  1  engine accepts an activation vector
- a_data  in  ROWS*DATA_WIDTH  lane r = a[r]
- a_last  in  1  final vector of the current stream
- y_valid  out  1  result vector valid
- y_ready  in  1  downstream accepts result
- y_data  out  COLS*ACCUM_WIDTH  lane c = y[c]
- y_last  out  1  result of the a_last vector
- busy  out  1  high unless in LOAD with zero weight rows received

## Operation
- States: LOAD, STREAM, DRAIN. Reset state LOAD.
- LOAD: w_ready=1, a_ready=0. Beat i (counter 0..ROWS-1) writes W[i][*] into PE row i. Counter wrap at ROWS-1 -> STREAM, counter cleared.
- STREAM: w_ready=0; a_ready=adv, where adv = !y_valid || y_ready (global pipeline advance). Accepted vector enters skew with valid=1; adv without a_valid inserts a bubble (valid=0). Accepted a_last -> DRAIN.
- DRAIN: a_ready=0, w_ready=0. Handshake y_valid&&y_ready&&y_last -> LOAD. Weights never change while any token is in flight.
- Datapath: row r skewed by r registers; PE[r][c] registers act rightward and psum downward; column c deskewed by COLS-1-c registers; one output register. Valid and last bits travel with tokens. All pipeline registers advance only on adv.
- Arithmetic: signed product, sign-extended to ACCUM_WIDTH, added to incoming psum (row 0 psum-in = 0); wraps modulo 2^ACCUM_WIDTH unless saturation is compiled in.
- Ignored inputs: w_valid outside LOAD, a_valid/a_last outside STREAM.
- Reset (any time, mid-stream included): state LOAD, weights 0, all valid/last bits 0, counter 0. Reset values: w_ready=1, a_ready=0, y_valid=0, y_last=0, y_data=0, busy=0.

## Timing
- Latency: vector accepted at edge k -> y_valid visible after edge k+ROWS+COLS-1, counting only adv edges (2x2: 3).
- Throughput one vector per cycle while y_ready=1.
- y_valid&&!y_ready: y_data/y_last stable, all stages and a_ready frozen (a_ready=0 same cycle).
- LOAD->STREAM: a_ready may go high the cycle after the final weight beat.
- Single-vector stream (a_last on first beat) valid; DRAIN lasts until its result handshakes.

## Configuration
- SYSTOLIC_SAT_EN defined: each PE addition clamps to [-2^(ACCUM_WIDTH-1), 2^(ACCUM_WIDTH-1)-1]; saturation sticks through later rows.
- Undefined: two's-complement wrap. No other difference in timing or interface.

## Structure
- systolic_pkg: state enum (LOAD/STREAM/DRAIN), shared default widths, helper for signed saturating add.
- Sub-module systolic_pe: weight register with load enable, act/psum registers, advance enable, MAC; generate grid of ROWS x COLS instances.

## Test plan
- 2x2, W=[[1,2],[3,4]], vectors [10,30] then [20,40] (last), y_ready=1 -> y=[100,140] then [140,200] with y_last, first 3 cycles after acceptance.
- Backpressure: y_ready low 4 cycles mid-stream -> y_data held, a_ready=0, no loss/duplication, order preserved.
- Bubbles: a_valid toggled 1,0,1 -> results with one-cycle y_valid gap; w_valid driven during STREAM ignored (W unchanged).
- Sign/overflow: W=-128, a=32767, ACCUM_WIDTH=24, ROWS=4 summing -> wraps without macro, clamps to -8388608 with SYSTOLIC_SAT_EN.
- Reset mid-stream after 2 accepted vectors -> y_valid=0 next, state LOAD, w_ready=1, re-load gives correct fresh results.
- 4x3 non-square random W/a vs reference model, 100 vectors, random y_ready -> bit-exact, latency 6 under no stall.

Source files
------------

// File: rtl/systolic_matmul_engine_pkg.sv
// Shared types, default widths and the saturating-add helper for the systolic matrix-vector engine.
package systolic_matmul_engine_pkg;

    localparam int DEF_ROWS         = 4;
    localparam int DEF_COLS         = 4;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_WEIGHT_WIDTH = 8;
    localparam int DEF_ACCUM_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    // Operands must already lie inside the signed 'width'-bit range (width <= 62).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] x,
                                                   input logic signed [63:0] y,
                                                   input int unsigned width);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = x + y;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Weight, activation and result handshakes of the systolic engine, bundled with master/slave views.
interface systolic_matmul_engine_if import systolic_matmul_engine_pkg::*; #(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH
);
    logic                          w_valid;
    logic                          w_ready;
    logic [COLS*WEIGHT_WIDTH-1:0]  w_data;
    logic                          a_valid;
    logic                          a_ready;
    logic [ROWS*DATA_WIDTH-1:0]    a_data;
    logic                          a_last;
    logic                          y_valid;
    logic                          y_ready;
    logic [COLS*ACCUM_WIDTH-1:0]   y_data;
    logic                          y_last;
    logic                          busy;

    modport master (
        output w_valid, w_data, a_valid, a_data, a_last, y_ready,
        input  w_ready, a_ready, y_valid, y_data, y_last, busy
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data, a_last, y_ready,
        output w_ready, a_ready, y_valid, y_data, y_last, busy
    );
endinterface

// File: rtl/systolic_matmul_engine_pe.sv
// One weight-stationary MAC cell: held weight, registered activation passed right, registered psum passed down.
// SYSTOLIC_SAT_EN selects a clamping accumulate instead of two's-complement wrap.
module systolic_pe import systolic_matmul_engine_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_adv,
    input  logic                           i_w_load,
    input  logic signed [WEIGHT_WIDTH-1:0] i_weight,
    input  logic signed [DATA_WIDTH-1:0]   i_act,
    input  logic signed [ACCUM_WIDTH-1:0]  i_psum,
    output logic signed [DATA_WIDTH-1:0]   o_act,
    output logic signed [ACCUM_WIDTH-1:0]  o_psum
);
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

    logic signed [WEIGHT_WIDTH-1:0] r_weight;
    logic signed [DATA_WIDTH-1:0]   r_act;
    logic signed [ACCUM_WIDTH-1:0]  r_psum;
    logic signed [PW-1:0]           w_prod;
    logic signed [ACCUM_WIDTH-1:0]  w_sum;

    assign w_prod = PW'(i_act) * PW'(r_weight);

`ifdef SYSTOLIC_SAT_EN
    assign w_sum = ACCUM_WIDTH'(sat_add(64'(i_psum), 64'(w_prod), ACCUM_WIDTH));
`else
    assign w_sum = i_psum + ACCUM_WIDTH'(w_prod);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weight <= '0;
            r_act    <= '0;
            r_psum   <= '0;
        end else begin
            if (i_w_load) r_weight <= i_weight;
            if (i_adv) begin
                r_act  <= i_act;
                r_psum <= w_sum;
            end
        end
    end

    assign o_act  = r_act;
    assign o_psum = r_psum;
endmodule

// File: rtl/systolic_matmul_engine.sv
// ROWS x COLS weight-stationary systolic matrix-vector engine with skew/deskew and global backpressure.
// Define SYSTOLIC_SAT_EN to build saturating PE accumulation.
module systolic_matmul_engine import systolic_matmul_engine_pkg::*; #(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int WEIGHT_WIDTH = DEF_WEIGHT_WIDTH,
    parameter int ACCUM_WIDTH  = DEF_ACCUM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    systolic_matmul_engine_if.slave bus
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Token tag depth: edge of acceptance through the output register.
    localparam int N  = ROWS + COLS;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_wcnt;
    logic [N-1:0]      r_vld;
    logic [N-1:0]      r_lst;
    logic [COLS*ACCUM_WIDTH-1:0] r_y_data;

    logic              w_adv;
    logic              w_w_fire;
    logic              w_a_fire;
    logic              w_y_fire;
    logic              w_wcnt_wrap;
    logic              w_y_vld;
    logic              w_y_lst;
    logic [ROWS-1:0]   w_wload;

    logic signed [DATA_WIDTH-1:0]  w_act [ROWS][COLS];
    logic signed [DATA_WIDTH-1:0]  w_act_unused [ROWS];
    logic signed [ACCUM_WIDTH-1:0] w_psum [ROWS+1][COLS];
    logic signed [ACCUM_WIDTH-1:0] w_dsk [COLS];

    assign w_y_vld     = r_vld[N-1];
    assign w_y_lst     = r_lst[N-1];
    assign w_adv       = !w_y_vld || bus.y_ready;
    assign w_w_fire    = (r_state == ST_LOAD) && bus.w_valid;
    assign w_wcnt_wrap = (r_wcnt == CW'(ROWS - 1));
    assign w_a_fire    = (r_state == ST_STREAM) && bus.a_valid && w_adv;
    assign w_y_fire    = w_y_vld && bus.y_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_LOAD;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:   if (w_w_fire && w_wcnt_wrap) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_a_fire && bus.a_last)  w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_y_fire && w_y_lst)     w_state_nxt = ST_LOAD;
            default:   w_state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        bus.w_ready = 1'b0;
        bus.a_ready = 1'b0;
        case (r_state)
            ST_LOAD:   bus.w_ready = 1'b1;
            ST_STREAM: bus.a_ready = w_adv;
            default:   ;
        endcase
        bus.busy = !((r_state == ST_LOAD) && (r_wcnt == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_wcnt <= '0;
        else if (w_w_fire) r_wcnt <= w_wcnt_wrap ? '0 : r_wcnt + CW'(1);
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic signed [DATA_WIDTH-1:0] w_a_lane;
        assign w_a_lane   = bus.a_data[r*DATA_WIDTH +: DATA_WIDTH];
        assign w_wload[r] = w_w_fire && (r_wcnt == CW'(r));

        if (r == 0) begin : g_noskew
            assign w_act[r][0] = w_a_lane;
        end else begin : g_skew
            logic signed [DATA_WIDTH-1:0] r_skew [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) r_skew[i] <= '0;
                end else if (w_adv) begin
                    r_skew[0] <= w_a_lane;
                    for (int i = 1; i < r; i++) r_skew[i] <= r_skew[i-1];
                end
            end
            assign w_act[r][0] = r_skew[r-1];
        end

        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == COLS - 1) begin : g_edge
                systolic_pe #(
                    .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH), .ACCUM_WIDTH(ACCUM_WIDTH)
                ) u_pe (
                    .clk(clk), .rst_n(rst_n), .i_adv(w_adv), .i_w_load(w_wload[r]),
                    .i_weight(bus.w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
                    .i_act(w_act[r][c]), .i_psum(w_psum[r][c]),
                    .o_act(w_act_unused[r]), .o_psum(w_psum[r+1][c])
                );
            end else begin : g_inner
                systolic_pe #(
                    .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH), .ACCUM_WIDTH(ACCUM_WIDTH)
                ) u_pe (
                    .clk(clk), .rst_n(rst_n), .i_adv(w_adv), .i_w_load(w_wload[r]),
                    .i_weight(bus.w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
                    .i_act(w_act[r][c]), .i_psum(w_psum[r][c]),
                    .o_act(w_act[r][c+1]), .o_psum(w_psum[r+1][c])
                );
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        assign w_psum[0][c] = '0;
        if (c == COLS - 1) begin : g_direct
            assign w_dsk[c] = w_psum[ROWS][c];
        end else begin : g_delay
            logic signed [ACCUM_WIDTH-1:0] r_dq [COLS-1-c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < COLS - 1 - c; i++) r_dq[i] <= '0;
                end else if (w_adv) begin
                    r_dq[0] <= w_psum[ROWS][c];
                    for (int i = 1; i < COLS - 1 - c; i++) r_dq[i] <= r_dq[i-1];
                end
            end
            assign w_dsk[c] = r_dq[COLS-2-c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_data <= '0;
            r_vld    <= '0;
            r_lst    <= '0;
        end else if (w_adv) begin
            for (int c = 0; c < COLS; c++) r_y_data[c*ACCUM_WIDTH +: ACCUM_WIDTH] <= w_dsk[c];
            r_vld <= N'({r_vld, w_a_fire});
            r_lst <= N'({r_lst, w_a_fire && bus.a_last});
        end
    end

    assign bus.y_valid = w_y_vld;
    assign bus.y_last  = w_y_lst;
    assign bus.y_data  = r_y_data;
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboard bench: a 2x2 engine for directed handshake cases and a 4x3 (24-bit accumulator) engine for overflow and random traffic.
module tb_systolic_matmul_engine;

    typedef struct { logic [63:0] d; logic l; int k; bit lat; } exp_a_t;
    typedef struct { logic [71:0] d; logic l; int k; bit lat; } exp_b_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   b_rand = 1'b0;
    exp_a_t qa[$];
    exp_b_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_matmul_engine_if #(.ROWS(2), .COLS(2), .DATA_WIDTH(16), .WEIGHT_WIDTH(8), .ACCUM_WIDTH(32)) ifa ();
    systolic_matmul_engine_if #(.ROWS(4), .COLS(3), .DATA_WIDTH(16), .WEIGHT_WIDTH(8), .ACCUM_WIDTH(24)) ifb ();

    systolic_matmul_engine #(.ROWS(2), .COLS(2), .DATA_WIDTH(16), .WEIGHT_WIDTH(8), .ACCUM_WIDTH(32))
        dut_a (.clk(clk), .rst_n(rst_a_n), .bus(ifa));
    systolic_matmul_engine #(.ROWS(4), .COLS(3), .DATA_WIDTH(16), .WEIGHT_WIDTH(8), .ACCUM_WIDTH(24))
        dut_b (.clk(clk), .rst_n(rst_b_n), .bus(ifb));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] pack2(input int y0, input int y1);
        return {32'(y1), 32'(y0)};
    endfunction

    // ---------------- 2x2 engine drivers ----------------
    task automatic a_wbeat(input logic [15:0] d);
        bit ok = 1'b0;
        ifa.w_valid = 1'b1;
        ifa.w_data  = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = ifa.w_ready;
            @(posedge clk); #1;
        end
        ifa.w_valid = 1'b0;
        if (!ok) chk("a_w_timeout", 128'(0), 128'(1));
    endtask

    task automatic a_send(input logic [31:0] d, input logic [63:0] e, input logic last, input bit lat);
        bit ok = 1'b0;
        exp_a_t x;
        ifa.a_valid = 1'b1;
        ifa.a_data  = d;
        ifa.a_last  = last;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = ifa.a_ready;
            @(posedge clk); #1;
        end
        ifa.a_valid = 1'b0;
        ifa.a_last  = 1'b0;
        if (!ok) chk("a_a_timeout", 128'(0), 128'(1));
        else begin
            x.d = e; x.l = last; x.k = cyc; x.lat = lat;
            qa.push_back(x);
        end
    endtask

    task automatic a_load_w1234();
        a_wbeat({8'd2, 8'd1});
        a_wbeat({8'd4, 8'd3});
    endtask

    task automatic a_drain(input int budget);
        for (int t = 0; t < budget && qa.size() != 0; t++) @(posedge clk);
        @(posedge clk); #1;
        chk("a_drain_left", 128'(qa.size()), 128'(0));
        chk("a_back_to_load", 128'({ifa.w_ready, ifa.a_ready, ifa.busy}), 128'(3'b100));
    endtask

    task automatic a_stall();
        logic [63:0] held;
        int t;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!ifa.y_valid && t < 50);
        ifa.y_ready = 1'b0;
        held = ifa.y_data;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a_bp_valid", 128'(ifa.y_valid), 128'(1));
            chk("a_bp_a_ready", 128'(ifa.a_ready), 128'(0));
            chk("a_bp_hold", 128'(ifa.y_data), 128'(held));
            @(posedge clk); #1;
        end
        ifa.y_ready = 1'b1;
    endtask

    // ---------------- 4x3 engine drivers ----------------
    task automatic b_wbeat(input logic [23:0] d);
        bit ok = 1'b0;
        ifb.w_valid = 1'b1;
        ifb.w_data  = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = ifb.w_ready;
            @(posedge clk); #1;
        end
        ifb.w_valid = 1'b0;
        if (!ok) chk("b_w_timeout", 128'(0), 128'(1));
    endtask

    task automatic b_send(input logic [63:0] d, input logic [71:0] e, input logic last, input bit lat);
        bit ok = 1'b0;
        exp_b_t x;
        ifb.a_valid = 1'b1;
        ifb.a_data  = d;
        ifb.a_last  = last;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = ifb.a_ready;
            @(posedge clk); #1;
        end
        ifb.a_valid = 1'b0;
        ifb.a_last  = 1'b0;
        if (!ok) chk("b_a_timeout", 128'(0), 128'(1));
        else begin
            x.d = e; x.l = last; x.k = cyc; x.lat = lat;
            qb.push_back(x);
        end
    endtask

    task automatic b_drain(input int budget);
        for (int t = 0; t < budget && qb.size() != 0; t++) @(posedge clk);
        @(posedge clk); #1;
        chk("b_drain_left", 128'(qb.size()), 128'(0));
        chk("b_back_to_load", 128'({ifb.w_ready, ifb.a_ready, ifb.busy}), 128'(3'b100));
    endtask

    // ---------------- monitors ----------------
    initial begin : mon_a
        exp_a_t e;
        forever begin
            @(negedge clk);
            if (rst_a_n && ifa.y_valid && ifa.y_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 128'(ifa.y_data), 128'(0) - 128'(1));
                else begin
                    e = qa.pop_front();
                    chk("a_y_data", 128'(ifa.y_data), 128'(e.d));
                    chk("a_y_last", 128'(ifa.y_last), 128'(e.l));
                    if (e.lat) chk("a_latency", 128'(cyc - e.k), 128'(3));
                end
            end
        end
    end

    initial begin : mon_b
        exp_b_t e;
        forever begin
            @(negedge clk);
            if (rst_b_n && ifb.y_valid && ifb.y_ready) begin
                if (qb.size() == 0) chk("b_unexpected_out", 128'(ifb.y_data), 128'(0) - 128'(1));
                else begin
                    e = qb.pop_front();
                    chk("b_y_data", 128'(ifb.y_data), 128'(e.d));
                    chk("b_y_last", 128'(ifb.y_last), 128'(e.l));
                    if (e.lat) chk("b_latency", 128'(cyc - e.k), 128'(6));
                end
            end
        end
    end

    initial begin : drv_b_ready
        ifb.y_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ifb.y_ready = b_rand ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int wb [4][3];
        int av [4];
        int acc;
        logic [63:0] ad;
        logic [71:0] ye;
        logic [23:0] wd;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        ifa.w_valid = 1'b0; ifa.w_data = '0; ifa.a_valid = 1'b0; ifa.a_data = '0; ifa.a_last = 1'b0;
        ifa.y_ready = 1'b1;
        ifb.w_valid = 1'b0; ifb.w_data = '0; ifb.a_valid = 1'b0; ifb.a_data = '0; ifb.a_last = 1'b0;
        #2;
        chk("a_rst_ready", 128'({ifa.w_ready, ifa.a_ready}), 128'(2'b10));
        chk("a_rst_y", 128'({ifa.y_valid, ifa.y_last, ifa.busy}), 128'(0));
        chk("a_rst_ydata", 128'(ifa.y_data), 128'(0));
        chk("b_rst_state", 128'({ifb.w_ready, ifb.a_ready, ifb.y_valid, ifb.busy}), 128'(4'b1000));
        @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(posedge clk); #1;

        // Basic 2x2: W=[[1,2],[3,4]]
        a_wbeat({8'd2, 8'd1});
        chk("a_busy_mid_load", 128'({ifa.busy, ifa.w_ready}), 128'(2'b11));
        a_wbeat({8'd4, 8'd3});
        chk("a_stream_ready", 128'({ifa.w_ready, ifa.a_ready}), 128'(2'b01));
        a_send({16'd30, 16'd10}, pack2(100, 140), 1'b0, 1'b1);
        a_send({16'd40, 16'd20}, pack2(140, 200), 1'b1, 1'b1);
        a_drain(100);

        // Bubbles, with junk weight beats offered during STREAM
        a_load_w1234();
        ifa.w_valid = 1'b1;
        ifa.w_data  = 16'hFFFF;
        a_send({16'd1, 16'd1}, pack2(4, 6), 1'b0, 1'b1);
        @(posedge clk); #1;
        a_send({16'd5, 16'hFFFE}, pack2(13, 16), 1'b1, 1'b1);
        ifa.w_valid = 1'b0;
        a_drain(100);

        // Backpressure: four stalled cycles mid-stream
        a_load_w1234();
        fork
            begin
                a_send({16'd0, 16'd1},       pack2(1, 2),   1'b0, 1'b0);
                a_send({16'd1, 16'd0},       pack2(3, 4),   1'b0, 1'b0);
                a_send({16'd2, 16'd2},       pack2(8, 12),  1'b0, 1'b0);
                a_send({16'hFFFF, 16'hFFFF}, pack2(-4, -6), 1'b0, 1'b0);
                a_send({16'hFFFF, 16'd3},    pack2(0, 2),   1'b0, 1'b0);
                a_send({16'd1, 16'd1},       pack2(4, 6),   1'b1, 1'b0);
            end
            a_stall();
        join
        a_drain(100);

        // Reset mid-stream after two accepted vectors
        a_load_w1234();
        a_send({16'd30, 16'd10}, pack2(100, 140), 1'b0, 1'b0);
        a_send({16'd40, 16'd20}, pack2(140, 200), 1'b0, 1'b0);
        rst_a_n = 1'b0;
        qa.delete();
        #1;
        chk("a_midrst_ready", 128'({ifa.w_ready, ifa.a_ready, ifa.busy}), 128'(3'b100));
        chk("a_midrst_y", 128'({ifa.y_valid, ifa.y_last, ifa.y_data}), 128'(0));
        @(negedge clk);
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        chk("a_postrst_yvalid", 128'(ifa.y_valid), 128'(0));
        a_wbeat({8'd0, 8'd2});
        a_wbeat({8'd3, 8'd0});
        a_send({16'd7, 16'd5}, pack2(10, 21), 1'b1, 1'b1);
        a_drain(100);

        // 4x3, 24-bit accumulator: W=-128 everywhere, a=32767 everywhere
        for (int r = 0; r < 4; r++) b_wbeat({3{8'h80}});
`ifdef SYSTOLIC_SAT_EN
        b_send({4{16'h7FFF}}, {3{24'h800000}}, 1'b1, 1'b1);
`else
        b_send({4{16'h7FFF}}, {3{24'h000200}}, 1'b1, 1'b1);
`endif
        b_drain(100);

        // 4x3 random traffic against a behavioural sum, random y_ready
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                wb[r][c] = int'($urandom_range(200)) - 100;
                wd[c*8 +: 8] = 8'(wb[r][c]);
            end
            b_wbeat(wd);
        end
        b_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            for (int r = 0; r < 4; r++) begin
                av[r] = int'($urandom_range(2000)) - 1000;
                ad[r*16 +: 16] = 16'(av[r]);
            end
            for (int c = 0; c < 3; c++) begin
                acc = 0;
                for (int r = 0; r < 4; r++) acc += av[r] * wb[r][c];
                ye[c*24 +: 24] = 24'(acc);
            end
            b_send(ad, ye, (i == 99), 1'b0);
        end
        b_drain(1000);
        b_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
